// File: rtl/muldiv_sequencer_pkg.sv
// Shared opcode, state and constant definitions for the HI/LO multiply/divide unit.
package muldiv_sequencer_pkg;

    localparam int unsigned MULDIV_DATA_WIDTH = 32;
    localparam int unsigned MULDIV_OP_SIZE    = 6;
    localparam int unsigned MULDIV_CNT_WIDTH  = 6;

    // Pipeline opcode field values for the HI/LO instruction group
    localparam logic [MULDIV_OP_SIZE-1:0] OP_MFHI = 6'h10;
    localparam logic [MULDIV_OP_SIZE-1:0] OP_MTHI = 6'h11;
    localparam logic [MULDIV_OP_SIZE-1:0] OP_MFLO = 6'h12;
    localparam logic [MULDIV_OP_SIZE-1:0] OP_MTLO = 6'h13;
    localparam logic [MULDIV_OP_SIZE-1:0] OP_MULT = 6'h18;
    localparam logic [MULDIV_OP_SIZE-1:0] OP_DIV  = 6'h1A;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_RUN  = 2'd1,
        MULDIV_FIX  = 2'd2
    } muldiv_state_e;

    typedef enum logic {
        MULDIV_MODE_MUL = 1'b0,
        MULDIV_MODE_DIV = 1'b1
    } muldiv_mode_e;

    // Quotient returned when the divisor is zero
    localparam logic [MULDIV_DATA_WIDTH-1:0] MULDIV_DIV0_LO = '1;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: 2*DATA_WIDTH accumulator with one shift-add (multiply)
// or one restoring shift-subtract (divide) step per enabled cycle.
module muldiv_iter_core
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MULDIV_DATA_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic                    i_step,
    input  muldiv_mode_e            i_mode,
    input  logic [DATA_WIDTH-1:0]   i_opd,
    input  logic [DATA_WIDTH-1:0]   i_init,
    output logic [2*DATA_WIDTH-1:0] o_acc
);

    localparam int unsigned AW = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] r_opd;
    logic [AW-1:0]         r_acc;
    logic [AW-1:0]         w_next;
    logic [DATA_WIDTH:0]   w_sum;
    logic [AW:0]           w_shl;
    logic [DATA_WIDTH:0]   w_diff;

    // One iteration: multiply adds multiplicand to the upper half when the
    // multiplier LSB is set then shifts right; divide shifts left and keeps
    // the trial subtraction when it does not borrow.
    always_comb begin
        w_next = r_acc;
        w_sum  = {1'b0, r_acc[AW-1:DATA_WIDTH]} + {1'b0, r_opd};
        w_shl  = {r_acc, 1'b0};
        w_diff = w_shl[AW:DATA_WIDTH] - {1'b0, r_opd};
        if (i_mode == MULDIV_MODE_MUL) begin
            if (r_acc[0]) begin
                w_next = {w_sum, r_acc[DATA_WIDTH-1:1]};
            end else begin
                w_next = {1'b0, r_acc[AW-1:1]};
            end
        end else begin
            if (!w_diff[DATA_WIDTH]) begin
                w_next = {w_diff[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b1};
            end else begin
                w_next = w_shl[AW-1:0];
            end
        end
    end

    // Accumulator and fixed operand registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_opd <= '0;
            r_acc <= '0;
        end else if (i_load) begin
            r_opd <= i_opd;
            r_acc <= {{DATA_WIDTH{1'b0}}, i_init};
        end else if (i_step) begin
            r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: accepts MULT/DIV/MTHI/MTLO, runs the
// iterative core for DATA_WIDTH cycles, applies sign correction and stalls
// HI/LO instructions that would collide with an operation in flight.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MULDIV_DATA_WIDTH,
    parameter int unsigned OP_SIZE    = MULDIV_OP_SIZE,
    parameter int unsigned CNT_WIDTH  = MULDIV_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_issue_valid,
    input  logic [OP_SIZE-1:0]    i_operation,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int unsigned AW = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    muldiv_state_e         r_state;
    muldiv_mode_e          r_mode;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_div0;
    logic [DATA_WIDTH-1:0] r_a_raw;
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_is_mult;
    logic                  w_is_div;
    logic                  w_is_mthi;
    logic                  w_is_mtlo;
    logic                  w_hl_op;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_step;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH-1:0] w_core_opd;
    logic [DATA_WIDTH-1:0] w_core_init;
    logic [AW-1:0]         w_acc;
    logic [AW-1:0]         w_prod;
    logic [DATA_WIDTH-1:0] w_quot;
    logic [DATA_WIDTH-1:0] w_rem;
    logic [DATA_WIDTH-1:0] w_res_hi;
    logic [DATA_WIDTH-1:0] w_res_lo;

    // Opcode decode, stall and accept qualification
    always_comb begin
        w_is_mult = (i_operation == OP_SIZE'(OP_MULT));
        w_is_div  = (i_operation == OP_SIZE'(OP_DIV));
        w_is_mthi = (i_operation == OP_SIZE'(OP_MTHI));
        w_is_mtlo = (i_operation == OP_SIZE'(OP_MTLO));
        w_hl_op   = w_is_mult | w_is_div | w_is_mthi | w_is_mtlo
                  | (i_operation == OP_SIZE'(OP_MFHI))
                  | (i_operation == OP_SIZE'(OP_MFLO));
        o_stall   = i_issue_valid & w_hl_op & r_busy & ~i_flush;
        w_accept  = i_issue_valid & ~o_stall & ~i_flush & (r_state == MULDIV_IDLE);
        w_start   = w_accept & (w_is_mult | w_is_div);
        w_step    = (r_state == MULDIV_RUN) & ~i_flush;
    end

    // Operand magnitudes and core load routing (multiplicand/divisor held fixed)
    always_comb begin
        w_a_mag     = i_operand_a[DATA_WIDTH-1] ? -i_operand_a : i_operand_a;
        w_b_mag     = i_operand_b[DATA_WIDTH-1] ? -i_operand_b : i_operand_b;
        w_core_opd  = w_is_div ? w_b_mag : w_a_mag;
        w_core_init = w_is_div ? w_a_mag : w_b_mag;
    end

    muldiv_iter_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_start),
        .i_step (w_step),
        .i_mode (r_mode),
        .i_opd  (w_core_opd),
        .i_init (w_core_init),
        .o_acc  (w_acc)
    );

    // Sign correction of the finished magnitude result
    always_comb begin
        w_prod = r_neg_q ? -w_acc : w_acc;
        w_quot = r_neg_q ? -w_acc[DATA_WIDTH-1:0] : w_acc[DATA_WIDTH-1:0];
        w_rem  = r_neg_r ? -w_acc[AW-1:DATA_WIDTH] : w_acc[AW-1:DATA_WIDTH];
        if (r_mode == MULDIV_MODE_MUL) begin
            w_res_hi = w_prod[AW-1:DATA_WIDTH];
            w_res_lo = w_prod[DATA_WIDTH-1:0];
        end else if (r_div0) begin
            w_res_hi = r_a_raw;
            w_res_lo = DATA_WIDTH'(MULDIV_DIV0_LO);
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end
    end

    // Control FSM, iteration counter, latched signs and HI/LO registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= MULDIV_IDLE;
            r_mode  <= MULDIV_MODE_MUL;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_a_raw <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MULDIV_IDLE: begin
                    if (w_start) begin
                        r_mode  <= w_is_div ? MULDIV_MODE_DIV : MULDIV_MODE_MUL;
                        r_neg_q <= i_operand_a[DATA_WIDTH-1] ^ i_operand_b[DATA_WIDTH-1];
                        r_neg_r <= i_operand_a[DATA_WIDTH-1];
                        r_div0  <= (i_operand_b == '0);
                        r_a_raw <= i_operand_a;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MULDIV_RUN;
                    end else if (w_accept & w_is_mthi) begin
                        r_hi <= i_operand_a;
                    end else if (w_accept & w_is_mtlo) begin
                        r_lo <= i_operand_a;
                    end
                end
                MULDIV_RUN: begin
                    if (i_flush) begin
                        r_busy  <= 1'b0;
                        r_state <= MULDIV_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                        if (r_cnt == LAST_CNT) begin
                            r_state <= MULDIV_FIX;
                        end
                    end
                end
                MULDIV_FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= MULDIV_IDLE;
                    if (!i_flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= MULDIV_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule
